// File: rtl/pow_calc_if.sv
// Handshake and data bundle for the integer power generator.
// The requester drives start/enable/c/e. The power block returns g/done/ovf/busy.
interface pow_calc_if #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 16
);
    logic                 start;
    logic                 enable;
    logic [WIDTH-1:0]     c;
    logic [EXP_WIDTH-1:0] e;
    logic [WIDTH-1:0]     g;
    logic                 done;
    logic                 ovf;
    logic                 busy;

    modport master (
        output start, enable, c, e,
        input  g, done, ovf, busy
    );

    modport slave (
        input  start, enable, c, e,
        output g, done, ovf, busy
    );
endinterface

// File: rtl/pow_calc.sv
// Integer power generator: g = c^e using square-and-multiply.
// The exponent is consumed one bit per clock, LSB first.
// A result wider than WIDTH bits saturates g to all ones and raises ovf.
module pow_calc #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    pow_calc_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_n;

    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     base;
    logic [EXP_WIDTH-1:0] e_sh;
    logic                 acc_ovf;
    logic                 base_ovf;

    logic [WIDTH-1:0]     g_r;
    logic                 done_r;
    logic                 ovf_r;

    logic                 accept;
    logic                 finish;
    logic                 step;

    logic [2*WIDTH-1:0]   prod_p;
    logic [2*WIDTH-1:0]   sq_p;

    // Clamp a result to all ones once any overflow has been seen.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] v,
                                                  input logic            o);
        return o ? {WIDTH{1'b1}} : v;
    endfunction

    // Full-width products.
    // The upper halves reveal overflow of the accumulator and of the squared base.
    assign prod_p = {{WIDTH{1'b0}}, acc}  * {{WIDTH{1'b0}}, base};
    assign sq_p   = {{WIDTH{1'b0}}, base} * {{WIDTH{1'b0}}, base};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and per-cycle strobes.
    // In RUN, a low enable wins over completion so that an abort never produces done.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        finish  = 1'b0;
        step    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && bus.enable) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (!bus.enable) begin
                    state_n = IDLE;
                end else if (e_sh == '0) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Square-and-multiply datapath and result registers.
    // g/ovf move only on completion, so they hold across accepts and aborts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            base     <= '0;
            e_sh     <= '0;
            acc_ovf  <= 1'b0;
            base_ovf <= 1'b0;
            g_r      <= '0;
            done_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            done_r <= finish;
            if (accept) begin
                acc      <= {{(WIDTH-1){1'b0}}, 1'b1};
                base     <= bus.c;
                e_sh     <= bus.e;
                acc_ovf  <= 1'b0;
                base_ovf <= 1'b0;
            end
            if (finish) begin
                g_r   <= saturate(acc, acc_ovf);
                ovf_r <= acc_ovf;
            end
            if (step) begin
                // A truncated base only matters once a set exponent bit multiplies it in.
                if (e_sh[0]) begin
                    acc     <= prod_p[WIDTH-1:0];
                    acc_ovf <= acc_ovf | (|prod_p[2*WIDTH-1:WIDTH]) | base_ovf;
                end
                base     <= sq_p[WIDTH-1:0];
                base_ovf <= base_ovf | (|sq_p[2*WIDTH-1:WIDTH]);
                e_sh     <= e_sh >> 1;
            end
        end
    end

    assign bus.g    = g_r;
    assign bus.done = done_r;
    assign bus.ovf  = ovf_r;
    assign bus.busy = (state == RUN);

endmodule

// File: tb/tb_pow_calc.sv
// Bench for pow_calc.
// A transaction-level model predicts g/ovf/done/busy every cycle. Directed cases pin the model with literal results.
module tb_pow_calc;

    localparam int WIDTH     = 16;
    localparam int EXP_WIDTH = 16;

    logic clk;
    logic rst;

    pow_calc_if #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH)) bus ();

    pow_calc #(.WIDTH(WIDTH), .EXP_WIDTH(EXP_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int bitlen(input logic [EXP_WIDTH-1:0] v);
        int n = 0;
        while (v != 0) begin
            n++;
            v = v >> 1;
        end
        return n;
    endfunction

    // Plain repeated multiplication; stops early once the answer is known.
    function automatic void ref_pow(input longint cc, input int ee,
                                    output longint r, output bit o);
        r = 1;
        o = 1'b0;
        for (int i = 0; i < ee; i++) begin
            r = r * cc;
            if (r > 65535) begin
                o = 1'b1;
                break;
            end
            if (r <= 1) break;
        end
    endfunction

    bit     m_busy;
    int     m_left;
    longint m_res;
    bit     m_rovf;
    logic [WIDTH-1:0] m_g;
    bit     m_ovf;
    bit     m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_left = 0;
            m_g    = '0;
            m_ovf  = 1'b0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (bus.start && bus.enable) begin
                    m_busy = 1'b1;
                    m_left = bitlen(bus.e) + 1;
                    ref_pow(longint'(bus.c), int'(bus.e), m_res, m_rovf);
                end
            end else if (!bus.enable) begin
                m_busy = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_g    = m_rovf ? {WIDTH{1'b1}} : m_res[WIDTH-1:0];
                    m_ovf  = m_rovf;
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            chk("done", bus.done, m_done);
            chk("busy", bus.busy, m_busy);
            chk("g",    bus.g,    m_g);
            chk("ovf",  bus.ovf,  m_ovf);
        end
    end

    // ---------------- stimulus ----------------
    // Called #1 after a rising edge with the DUT idle. Returns edges from accept to done.
    task automatic op(input logic [15:0] cc, input logic [15:0] ee, input bit rnd_abort,
                      output int lat, output bit got);
        bus.start  = 1'b1;
        bus.enable = 1'b1;
        bus.c      = cc;
        bus.e      = ee;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.c     = 16'($urandom);
        bus.e     = 16'($urandom);
        lat = 0;
        got = 1'b0;
        while (lat < 40) begin
            bus.enable = (rnd_abort && $urandom_range(15) == 0) ? 1'b0 : 1'b1;
            @(posedge clk);
            lat++;
            #1;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (!bus.busy) break;
        end
        bus.enable = 1'b1;
        if (!rnd_abort) chk("op_done", got, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit got;
        logic [15:0] rc;
        logic [15:0] re;

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.enable = 1'b0;
        bus.c      = '0;
        bus.e      = '0;
        #2;
        chk("rst_g",    bus.g,    0);
        chk("rst_done", bus.done, 0);
        chk("rst_ovf",  bus.ovf,  0);
        chk("rst_busy", bus.busy, 0);
        #20 rst = 1'b0;
        @(posedge clk);
        #1;

        op(16'd3, 16'd4, 1'b0, lat, got);
        chk("c3e4_g", bus.g, 81);
        chk("c3e4_ovf", bus.ovf, 0);
        chk("c3e4_lat", lat, 4);

        op(16'd2, 16'd15, 1'b0, lat, got);
        chk("c2e15_g", bus.g, 16'h8000);
        chk("c2e15_ovf", bus.ovf, 0);

        op(16'd2, 16'd16, 1'b0, lat, got);
        chk("c2e16_g", bus.g, 16'hFFFF);
        chk("c2e16_ovf", bus.ovf, 1);

        op(16'd0, 16'd0, 1'b0, lat, got);
        chk("c0e0_g", bus.g, 1);
        chk("c0e0_lat", lat, 1);

        op(16'd0, 16'd5, 1'b0, lat, got);
        chk("c0e5_g", bus.g, 0);

        op(16'd1, 16'hFFFF, 1'b0, lat, got);
        chk("c1eFFFF_g", bus.g, 1);
        chk("c1eFFFF_lat", lat, 17);

        op(16'd255, 16'd2, 1'b0, lat, got);
        chk("c255e2_g", bus.g, 65025);
        chk("c255e2_ovf", bus.ovf, 0);

        // Abort on the second RUN cycle: outputs keep 65025/0.
        bus.start  = 1'b1;
        bus.enable = 1'b1;
        bus.c      = 16'd3;
        bus.e      = 16'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_g", bus.g, 65025);
        chk("abort_done", bus.done, 0);
        bus.enable = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_g_hold", bus.g, 65025);
        op(16'd3, 16'd4, 1'b0, lat, got);
        chk("after_abort_g", bus.g, 81);

        // Asynchronous reset between edges during RUN.
        bus.start = 1'b1;
        bus.c     = 16'd3;
        bus.e     = 16'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_g",    bus.g,    0);
        chk("arst_done", bus.done, 0);
        chk("arst_busy", bus.busy, 0);
        #10 rst = 1'b0;
        @(posedge clk);
        #1;
        op(16'd5, 16'd3, 1'b0, lat, got);
        chk("c5e3_g", bus.g, 125);

        // Back-to-back: start held high, e changes after the first accept.
        bus.start  = 1'b1;
        bus.enable = 1'b1;
        bus.c      = 16'd7;
        bus.e      = 16'd3;
        @(posedge clk);
        #1;
        bus.e = 16'd2;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            got = bus.done;
        end
        chk("b2b_first_done", got, 1);
        chk("b2b_g1", bus.g, 343);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b_done_drop", bus.done, 0);
        chk("b2b_busy2", bus.busy, 1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            got = bus.done;
        end
        chk("b2b_second_done", got, 1);
        chk("b2b_g2", bus.g, 49);

        // start without enable in IDLE is ignored.
        bus.start  = 1'b1;
        bus.enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("noen_busy", bus.busy, 0);
        bus.start  = 1'b0;
        bus.enable = 1'b1;

        // Randomized operations with occasional aborts and idle gaps.
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(3))
                0: rc = 16'($urandom_range(3));
                1: rc = 16'($urandom_range(20));
                2: rc = 16'($urandom_range(300));
                default: rc = 16'($urandom);
            endcase
            re = ($urandom_range(3) == 0) ? 16'($urandom) : 16'($urandom_range(20));
            op(rc, re, ($urandom_range(3) == 0), lat, got);
            if ($urandom_range(3) == 0) begin
                bus.start  = 1'b1;
                bus.enable = 1'b0;
                @(posedge clk);
                #1;
                bus.start  = 1'b0;
                bus.enable = 1'b1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
